// File: rtl/nes_controller_reader_if.sv
// ============================================================================
// Module      : nes_controller_reader_if
// Description : Controller-port and button-bus signal bundle for the NES reader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface nes_controller_reader_if;
    logic       enable;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_clock;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic       busy;

    // Reader side: drives the controller lines and the parallel button bus
    modport master (
        input  enable,
        input  nes_data,
        output nes_latch,
        output nes_clock,
        output buttons,
        output buttons_valid,
        output busy
    );

    // System/controller side
    modport slave (
        output enable,
        output nes_data,
        input  nes_latch,
        input  nes_clock,
        input  buttons,
        input  buttons_valid,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/nes_controller_reader.sv
// ============================================================================
// Module      : nes_controller_reader
// Description : Polls one NES controller port and presents the 8 buttons as an
//               active-high vector with a one-cycle valid strobe.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module nes_controller_reader #(
    parameter int CLK_FREQ   = 50000000,
    parameter int SHIFT_FREQ = 1000000,
    parameter int POLL_FREQ  = 750
) (
    input  wire logic                clk,
    input  wire logic                rst,
    nes_controller_reader_if.master  bus
);
    // Half shift-clock period must be at least 3 cycles so the synchronized
    // data settles before it is sampled at the end of each low half.
    localparam int c_half_cyc = CLK_FREQ / (2 * SHIFT_FREQ);
    localparam int c_poll_cyc = CLK_FREQ / POLL_FREQ;
    localparam int c_poll_w   = (c_poll_cyc > 1) ? $clog2(c_poll_cyc) : 1;
    localparam int c_phase_w  = $clog2(2 * c_half_cyc);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LATCH    = 3'd1,
        S_CLK_HIGH = 3'd2,
        S_CLK_LOW  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_poll_w-1:0]    r_poll;
    logic [c_phase_w-1:0]   r_phase;
    logic [2:0]             r_idx;
    logic [1:0]             r_sync;
    logic [7:0]             r_shift;
    logic [7:0]             r_buttons;
    logic                   r_latch;
    logic                   r_clock;
    logic                   r_valid;
    logic                   r_busy;

    logic                   w_poll_tick;
    logic                   w_latch_end;
    logic                   w_half_end;
    logic                   w_sample;
    logic [2:0]             w_bit;
    logic [7:0]             w_shift_nxt;

    assign w_poll_tick = (r_poll == c_poll_w'(c_poll_cyc - 1));
    assign w_latch_end = (r_phase == c_phase_w'(2 * c_half_cyc - 1));
    assign w_half_end  = (r_phase == c_phase_w'(c_half_cyc - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_poll_tick && bus.enable) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                if (w_latch_end) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_CLK_HIGH;
                end
            end
            S_CLK_HIGH: begin
                if (w_half_end) begin
                    w_state_nxt = S_CLK_LOW;
                end
            end
            S_CLK_LOW: begin
                if (w_half_end) begin
                    w_sample    = 1'b1;
                    w_state_nxt = (r_idx == 3'd7) ? S_DONE : S_CLK_HIGH;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Bit 0 (A) is valid while latch is high; later bits follow each clock
        w_bit       = (r_state == S_LATCH) ? 3'd0 : r_idx;
        w_shift_nxt = r_shift;
        if (w_sample) begin
            w_shift_nxt[w_bit] = ~r_sync[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_poll    <= '0;
            r_phase   <= '0;
            r_idx     <= 3'd0;
            r_sync    <= 2'b00;
            r_shift   <= 8'h00;
            r_buttons <= 8'h00;
            r_latch   <= 1'b0;
            r_clock   <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], bus.nes_data};
            r_poll <= w_poll_tick ? '0 : r_poll + c_poll_w'(1);

            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + c_phase_w'(1);
            end

            if (w_sample) begin
                r_shift <= w_shift_nxt;
                if (r_state == S_LATCH) begin
                    r_idx <= 3'd1;
                end else if (r_idx != 3'd7) begin
                    r_idx <= r_idx + 3'd1;
                end
            end

            // Publish on entry to DONE so the vector and strobe share a cycle
            if (w_state_nxt == S_DONE) begin
                r_buttons <= w_shift_nxt;
            end

            r_latch <= (w_state_nxt == S_LATCH);
            r_clock <= (w_state_nxt == S_CLK_HIGH);
            r_valid <= (w_state_nxt == S_DONE);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.nes_latch     = r_latch;
    assign bus.nes_clock     = r_clock;
    assign bus.buttons       = r_buttons;
    assign bus.buttons_valid = r_valid;
    assign bus.busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_nes_controller_reader.sv
// ============================================================================
// Module      : tb_nes_controller_reader
// Description : Directed bench for nes_controller_reader with a cycle-level
//               frame model (unit A: P=100, unit B: P=58 overrun), H=5.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_nes_controller_reader;
    localparam int H = 5;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    nes_controller_reader_if ifa ();
    nes_controller_reader_if ifb ();

    nes_controller_reader #(
        .CLK_FREQ   (1000),
        .SHIFT_FREQ (100),
        .POLL_FREQ  (10)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    nes_controller_reader #(
        .CLK_FREQ   (1000),
        .SHIFT_FREQ (100),
        .POLL_FREQ  (17)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Flattened views of both units
    logic       lat  [2];
    logic       sclk [2];
    logic       val  [2];
    logic       bsy  [2];
    logic [7:0] btn  [2];
    logic       rs   [2];
    logic       en   [2];
    logic [7:0] pat  [2];
    logic [2:0] k    [2];
    logic       prev_sclk [2];

    assign lat[0]  = ifa.nes_latch;     assign lat[1]  = ifb.nes_latch;
    assign sclk[0] = ifa.nes_clock;     assign sclk[1] = ifb.nes_clock;
    assign val[0]  = ifa.buttons_valid; assign val[1]  = ifb.buttons_valid;
    assign bsy[0]  = ifa.busy;          assign bsy[1]  = ifb.busy;
    assign btn[0]  = ifa.buttons;       assign btn[1]  = ifb.buttons;
    assign rs[0]   = rst_a;             assign rs[1]   = rst_b;
    assign en[0]   = ifa.enable;        assign en[1]   = ifb.enable;

    // Controller: bit 0 while latched, next bit after each shift-clock rise
    assign ifa.nes_data = ~pat[0][k[0]];
    assign ifb.nes_data = ~pat[1][k[1]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            prev_sclk[i] <= sclk[i];
            if (lat[i]) begin
                k[i] <= 3'd0;
            end else if (sclk[i] && !prev_sclk[i] && k[i] != 3'd7) begin
                k[i] <= k[i] + 3'd1;
            end
        end
    end

    // Activity counters for unit A
    int   latch_rises = 0;
    int   clk_rises   = 0;
    int   valid_cnt   = 0;
    logic prev_lat_a  = 1'b0;
    logic prev_clk_a  = 1'b0;

    always @(posedge clk) begin
        prev_lat_a <= ifa.nes_latch;
        prev_clk_a <= ifa.nes_clock;
        if (ifa.nes_latch && !prev_lat_a) latch_rises <= latch_rises + 1;
        if (ifa.nes_clock && !prev_clk_a) clk_rises   <= clk_rises + 1;
        if (ifa.buttons_valid)            valid_cnt   <= valid_cnt + 1;
    end

    // Frame model: a frame occupies cycles fstart..fstart+16H after an accepted tick
    int         cyc    [2];
    int         fstart [2];
    bit         infr   [2];
    logic [7:0] fpat   [2];
    logic [7:0] ebtn   [2];

    function automatic int poll_of(input int i);
        return (i == 0) ? 100 : 58;
    endfunction

    function automatic bit active(input int i, input int t);
        return infr[i] && (t >= fstart[i]) && (t <= fstart[i] + 16 * H);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rs[i]) begin
                cyc[i]  <= 0;
                infr[i] <= 1'b0;
                ebtn[i] <= 8'h00;
            end else begin
                cyc[i] <= cyc[i] + 1;
                if (active(i, cyc[i]) && (cyc[i] - fstart[i] == 16 * H)) ebtn[i] <= fpat[i];
                if (!active(i, cyc[i]) && (cyc[i] % poll_of(i) == poll_of(i) - 1) && en[i]) begin
                    fstart[i] <= cyc[i] + 1;
                    infr[i]   <= 1'b1;
                    fpat[i]   <= pat[i];
                end
            end
        end
    end

    function automatic logic [11:0] model_out(input int i);
        int         t;
        int         o;
        bit         a;
        logic       l;
        logic       c;
        logic       v;
        logic [7:0] b;
        if (rs[i]) return 12'h000;
        t = cyc[i];
        a = active(i, t);
        o = t - fstart[i];
        l = a && (o < 2 * H);
        c = a && (o >= 2 * H) && (o < 16 * H) && (((o - 2 * H) % (2 * H)) < H);
        v = a && (o == 16 * H);
        b = v ? fpat[i] : ebtn[i];
        return {l, c, v, a, b};
    endfunction

    logic [11:0] exp_v;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_v = model_out(i);
            chk((i == 0) ? "model_a" : "model_b", {20'h0, lat[i], sclk[i], val[i], bsy[i], btn[i]},
                {20'h0, exp_v});
        end
    end

    task automatic at(input int n);
        int guard;
        guard = 0;
        while (cyc[0] != n && guard <= 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard > 3000) chk("wait_bound", 32'd0, 32'd1);
    endtask

    int snap_l;
    int snap_c;
    int snap_v;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.enable = 1'b1;
        ifb.enable = 1'b1;
        pat[0] = 8'h09;
        pat[1] = 8'h3C;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ifa.nes_latch, ifa.nes_clock, ifa.buttons_valid, ifa.busy, ifa.buttons}, 12'h000);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        at(57);   chk("b_latch_57", ifb.nes_latch, 1'b0);
        at(58);   chk("b_latch_58", ifb.nes_latch, 1'b1);
        at(99);   chk("a_latch_99", ifa.nes_latch, 1'b0);
                  chk("a_btn_99", ifa.buttons, 8'h00);
        at(100);  chk("a_latch_100", ifa.nes_latch, 1'b1);
                  chk("a_busy_100", ifa.busy, 1'b1);
        at(109);  chk("a_latch_109", ifa.nes_latch, 1'b1);
        at(110);  chk("a_latch_clk_110", {ifa.nes_latch, ifa.nes_clock}, 2'b01);
        at(116);  chk("b_tick_dropped_116", ifb.nes_latch, 1'b0);
        at(138);  chk("b_valid_138", {ifb.buttons_valid, ifb.buttons}, {1'b1, 8'h3C});
        at(173);  chk("b_latch_173", ifb.nes_latch, 1'b0);
        at(174);  chk("b_latch_174", ifb.nes_latch, 1'b1);
        at(180);  chk("a_valid_180", {ifa.buttons_valid, ifa.buttons}, {1'b1, 8'h09});
                  chk("a_clk_pulses", clk_rises, 7);
        at(181);  chk("a_valid_181", {ifa.buttons_valid, ifa.buttons}, {1'b0, 8'h09});
        #1 pat[0] = 8'h00;

        at(279);  chk("a_hold_279", ifa.buttons, 8'h09);
        at(280);  chk("a_none_280", {ifa.buttons_valid, ifa.buttons}, {1'b1, 8'h00});
        #1 pat[0] = 8'hFF;
        at(379);  chk("a_hold_379", ifa.buttons, 8'h00);
        at(380);  chk("a_all_380", {ifa.buttons_valid, ifa.buttons}, {1'b1, 8'hFF});

        at(390);
        snap_l = latch_rises;
        snap_c = clk_rises;
        snap_v = valid_cnt;
        #1 ifa.enable = 1'b0;
        at(890);
        chk("a_disabled_latch", latch_rises, snap_l);
        chk("a_disabled_clk", clk_rises, snap_c);
        chk("a_disabled_valid", valid_cnt, snap_v);
        #1;
        pat[0] = 8'hA5;
        ifa.enable = 1'b1;

        at(930);  chk("a_bit3_clk_930", ifa.nes_clock, 1'b1);
        #1 ifa.enable = 1'b0;
        at(980);  chk("a_valid_980", {ifa.buttons_valid, ifa.buttons}, {1'b1, 8'hA5});
        snap_l = latch_rises;
        at(1250); chk("a_no_restart", latch_rises, snap_l);
        #1 ifa.enable = 1'b1;

        at(1342); chk("a_bit4_clk_1342", ifa.nes_clock, 1'b1);
        #1 rst_a = 1'b1;
        #1 chk("a_reset_midframe", {ifa.nes_latch, ifa.nes_clock, ifa.buttons_valid, ifa.busy, ifa.buttons},
               12'h000);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_a  = 1'b0;
        pat[0] = 8'h5A;

        at(99);   chk("a2_latch_99", ifa.nes_latch, 1'b0);
        at(100);  chk("a2_latch_100", ifa.nes_latch, 1'b1);
        at(180);  chk("a2_valid_180", {ifa.buttons_valid, ifa.buttons}, {1'b1, 8'h5A});

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
